// File: rtl/psg_mix_scheduler.sv
// PSG mixer: time-shares one attenuation ROM across all channels per sample tick
// and sums the attenuated outputs. Optional `PSG_MIX_SKIP_IDLE_EN skips ROM reads for silent slots.
module psg_mix_scheduler #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned LUT_W    = 8,
  parameter int unsigned SAMPLE_W = LUT_W + $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic [NUM_CH-1:0]     tone_out,
  input  logic [4*NUM_CH-1:0]   atten,
  output logic                  lut_rd,
  output logic [3:0]            lut_addr,
  input  logic [LUT_W-1:0]      lut_data,
  output logic [SAMPLE_W-1:0]   sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StAccum} state_e;

  state_e                state;
  logic [NUM_CH-1:0]     shadow_tone;
  logic [4*NUM_CH-1:0]   shadow_atten;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_nxt;
  logic [SAMPLE_W-1:0]   acc;
  logic [SAMPLE_W-1:0]   acc_sum;
  logic [LUT_W-1:0]      term;
  logic [3:0]            cur_atten;
  logic [3:0]            nxt_atten;
  logic                  first_rd;
  logic                  nxt_rd;

  always_comb begin
    idx_nxt   = idx + 1'b1;
    cur_atten = shadow_atten[4*idx +: 4];
    nxt_atten = shadow_atten[4*idx_nxt +: 4];
    // Attenuation 15 is a hard mute regardless of the ROM contents.
    term      = (shadow_tone[idx] && (cur_atten != 4'd15)) ? lut_data : '0;
    acc_sum   = acc + SAMPLE_W'(term);
`ifdef PSG_MIX_SKIP_IDLE_EN
    first_rd  = tone_out[0] && (atten[3:0] != 4'd15);
    nxt_rd    = shadow_tone[idx_nxt] && (nxt_atten != 4'd15);
`else
    first_rd  = 1'b1;
    nxt_rd    = 1'b1;
`endif
  end

  // Read strobe/address are registered one state early so they line up with FETCH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      idx          <= '0;
      acc          <= '0;
      shadow_tone  <= '0;
      shadow_atten <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      lut_rd       <= 1'b0;
      lut_addr     <= 4'd0;
    end else begin
      sample_valid <= 1'b0;
      lut_rd       <= 1'b0;
      lut_addr     <= 4'd0;

      if (sample_tick && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (sample_tick) begin
            shadow_tone  <= tone_out;
            shadow_atten <= atten;
            acc          <= '0;
            idx          <= '0;
            busy         <= 1'b1;
            state        <= StFetch;
            if (first_rd) begin
              lut_rd   <= 1'b1;
              lut_addr <= atten[3:0];
            end
          end
        end
        StFetch: begin
          state <= StAccum;
        end
        StAccum: begin
          acc <= acc_sum;
          if (idx == LastIdx) begin
            sample       <= acc_sum;
            sample_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= StIdle;
          end else begin
            idx   <= idx_nxt;
            state <= StFetch;
            if (nxt_rd) begin
              lut_rd   <= 1'b1;
              lut_addr <= nxt_atten;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
